matrix_stream_writer: RTL and testbench
=======================================

MATRIX_STREAM_WRITER -- requirements
Module: matrix_stream_writer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning element width in bits.
REQ-002 The block SHALL have parameter MAX_N, default 8, meaning maximum rows and columns supported.
REQ-003 The block SHALL have parameter IDX_W, default 5, meaning index width; IDX_W >= clog2(MAX_N+1).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge; no other clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: begin a matrix transfer; sampled only in IDLE.
REQ-007 The block SHALL have port col_major, input, 1 bit: traversal order, 0 row-major and 1 column-major; latched at start.
REQ-008 The block SHALL have port rows_cfg, input, IDX_W bits: row count; latched at start.
REQ-009 The block SHALL have port cols_cfg, input, IDX_W bits: column count; latched at start.
REQ-010 The block SHALL have port i, output, IDX_W bits: row address to the matrix memory.
REQ-011 The block SHALL have port j, output, IDX_W bits: column address to the matrix memory.
REQ-012 The block SHALL have port value, input, DATA_W bits: memory read data, valid one cycle after (i,j) is presented.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: stream payload.
REQ-014 The block SHALL have port out_valid, output, 1 bit: stream valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: stream ready from the sink.
REQ-016 The block SHALL have port out_last, output, 1 bit: marks the final element, qualified by out_valid.
REQ-017 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a transfer.

Function
REQ-019 The block SHALL implement the states IDLE, READ, SEND and FIN.
REQ-020 In IDLE with start=1, the block SHALL latch col_major, rows_cfg and cols_cfg and set i=0, j=0.
- If either dimension is 0, or greater than MAX_N, it SHALL go to FIN with no stream output.
- Otherwise it SHALL go to READ.
REQ-021 In READ the block SHALL hold (i,j) stable for one cycle and then go to SEND.
REQ-022 On entry to SEND the block SHALL register value into out_data and assert out_valid.
- out_data and out_valid SHALL stay stable until the handshake.
- Handshake = out_valid & out_ready at a rising edge.
REQ-023 On a SEND handshake with elements remaining, the block SHALL deassert out_valid, advance the index and return to READ.
- Row-major: j increments; at j=cols-1, j wraps to 0 and i increments.
- Column-major: i increments; at i=rows-1, i wraps to 0 and j increments.
REQ-024 out_last SHALL be 1 exactly while out_valid=1 and (i,j)=(rows-1,cols-1).
REQ-025 On the handshake of the last element, the block SHALL go to FIN and deassert out_valid and out_last.
REQ-026 In FIN the block SHALL assert done for exactly one cycle and return to IDLE the next cycle.
REQ-027 Latency SHALL be fixed:
- start edge to first out_valid: 2 cycles.
- Each handshake to the next out_valid: 2 cycles.
- Peak throughput is one element per 2 cycles when out_ready=1.
REQ-028 start asserted while busy=1 SHALL be ignored, and latched configuration SHALL not change mid-transfer.
REQ-029 The block SHALL exert no combinational path from out_ready to any output.
REQ-030 Each transfer SHALL emit exactly rows*cols elements, with no duplicates and no omissions under any out_ready pattern.

Reset
REQ-031 While rst_n=0, all outputs SHALL be 0 (i, j, out_data, out_valid, out_last, busy, done), asynchronously.
REQ-032 While rst_n=0, the state SHALL be IDLE and the latched configuration SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse.
REQ-034 After rst_n deasserts, the block SHALL accept a new start on the first rising edge.

Verification
REQ-035 The bench SHALL cover row-major 2x3 with memory value = 16*i+j and out_ready tied 1:
- Required stream: 0x00, 0x01, 0x02, 0x10, 0x11, 0x12.
- out_last SHALL be set only on 0x12.
- done SHALL pulse one cycle after the last handshake; 11 cycles from start to the last handshake.
REQ-036 The bench SHALL cover column-major 2x3 with the same memory:
- Required stream: 0x00, 0x10, 0x01, 0x11, 0x02, 0x12.
REQ-037 The bench SHALL cover 8x8 row-major with out_ready random at 30% duty:
- All 64 elements SHALL arrive in order.
- out_data SHALL remain stable while valid and not ready.
REQ-038 The bench SHALL cover rows_cfg=0, cols_cfg=5:
- out_valid SHALL never assert.
- busy SHALL be high for 1 cycle and done SHALL pulse once.
REQ-039 The bench SHALL cover 1x1 and 8x1 with start held high throughout:
- Each transfer completes with out_last on its final element.
- A second transfer SHALL start only after IDLE is re-entered.
REQ-040 The bench SHALL cover a reset pulse during element 5 of 4x4:
- All outputs SHALL go to 0 immediately, with no done pulse.
- A following 4x4 transfer SHALL complete correctly.

Source files
------------

// File: rtl/matrix_stream_writer_if.sv
// Bus bundle for matrix_stream_writer.
// Groups the control, memory-address, memory-data and output-stream signals.
//   start, col_major, rows_cfg, cols_cfg : transfer request and its configuration
//   i, j                                 : row/column address to the matrix memory
//   value                                : memory read data for the presented (i,j)
//   out_data, out_valid, out_ready       : element stream with valid/ready handshake
//   out_last                             : marks the final element of the transfer
//   busy, done                           : status (busy outside IDLE, done pulse at end)
// Modport slave is the writer side; modport master is the requester/memory/sink side.
interface matrix_stream_writer_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              start;
    logic              col_major;
    logic [IDX_W-1:0]  rows_cfg;
    logic [IDX_W-1:0]  cols_cfg;
    logic [IDX_W-1:0]  i;
    logic [IDX_W-1:0]  j;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    modport slave (
        input  start, col_major, rows_cfg, cols_cfg, value, out_ready,
        output i, j, out_data, out_valid, out_last, busy, done
    );

    modport master (
        output start, col_major, rows_cfg, cols_cfg, value, out_ready,
        input  i, j, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/matrix_stream_writer.sv
// Matrix stream writer: walks a rows x cols matrix in row- or column-major order,
// reads each element from an external memory through (i,j)/value and emits it on a
// valid/ready stream, flagging the final element with out_last.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears state, config and all outputs
//   bus   : matrix_stream_writer_if.slave (control, memory address/data, stream, status)
// Every output is a register, so out_ready has no combinational path to any output.
module matrix_stream_writer #(
    parameter int DATA_W = 32,
    parameter int MAX_N  = 8,
    parameter int IDX_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    matrix_stream_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StSend,
        StFin
    } state_e;

    localparam logic [IDX_W-1:0] MaxN = IDX_W'(MAX_N);
    localparam logic [IDX_W-1:0] One  = IDX_W'(1);

    state_e            r_state;
    logic              r_col_major;
    logic [IDX_W-1:0]  r_rows;
    logic [IDX_W-1:0]  r_cols;
    logic [IDX_W-1:0]  r_i;
    logic [IDX_W-1:0]  r_j;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;

    logic w_bad_cfg;
    logic w_row_end;
    logic w_col_end;
    logic w_at_last;
    logic w_hs;

    // Checked on the raw inputs because the decision is taken in the same cycle they latch.
    assign w_bad_cfg = (bus.rows_cfg == '0) || (bus.cols_cfg == '0) ||
                       (bus.rows_cfg > MaxN) || (bus.cols_cfg > MaxN);
    assign w_row_end = (r_j == r_cols - One);
    assign w_col_end = (r_i == r_rows - One);
    assign w_at_last = w_row_end && w_col_end;
    assign w_hs      = r_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_col_major <= 1'b0;
            r_rows      <= '0;
            r_cols      <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_col_major <= bus.col_major;
                        r_rows      <= bus.rows_cfg;
                        r_cols      <= bus.cols_cfg;
                        r_i         <= '0;
                        r_j         <= '0;
                        r_busy      <= 1'b1;
                        if (w_bad_cfg) begin
                            // Empty or oversized matrix: finish without streaming anything.
                            r_state <= StFin;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StRead;
                        end
                    end
                end
                StRead: begin
                    // Address has been stable for a full cycle, so value is valid now.
                    r_data  <= bus.value;
                    r_valid <= 1'b1;
                    r_last  <= w_at_last;
                    r_state <= StSend;
                end
                StSend: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (w_at_last) begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StRead;
                            if (!r_col_major) begin
                                if (w_row_end) begin
                                    r_j <= '0;
                                    r_i <= r_i + One;
                                end else begin
                                    r_j <= r_j + One;
                                end
                            end else begin
                                if (w_col_end) begin
                                    r_i <= '0;
                                    r_j <= r_j + One;
                                end else begin
                                    r_i <= r_i + One;
                                end
                            end
                        end
                    end
                end
                StFin: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.i         = r_i;
    assign bus.j         = r_j;
    assign bus.out_data  = r_data;
    assign bus.out_valid = r_valid;
    assign bus.out_last  = r_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_matrix_stream_writer.sv
// Scoreboard bench for matrix_stream_writer: stimulus pushes expected elements into a
// queue, a negedge monitor pops and compares on every stream handshake.
module tb_matrix_stream_writer;

    localparam int DATA_W = 32;
    localparam int MAX_N  = 8;
    localparam int IDX_W  = 5;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_stream_writer_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    matrix_stream_writer #(
        .DATA_W (DATA_W),
        .MAX_N  (MAX_N),
        .IDX_W  (IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Matrix memory model: element (i,j) holds 16*i + j.
    assign bus.value = (DATA_W'(bus.i) << 4) + DATA_W'(bus.j);

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    int   valid_cnt = 0;
    int   hs_cnt   = 0;
    int   last_hs_edge = 0;
    int   done_seen_cyc = 0;
    int   start_edge = 0;
    int   ready_pct = 100;
    bit   ready_hold = 1'b0;
    bit   stall = 1'b0;
    logic [DATA_W-1:0] stall_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sink ready driver.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_hold) bus.out_ready = 1'b0;
            else if (ready_pct >= 100) bus.out_ready = 1'b1;
            else bus.out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Monitor: a handshake seen here completes at the next rising edge (cyc + 1).
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (bus.done) begin
                done_cnt++;
                done_seen_cyc = cyc;
            end
            if (bus.busy) busy_cnt++;
            if (bus.out_valid) begin
                valid_cnt++;
                if (stall) chk("stable_data", bus.out_data, stall_data);
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_elem: got 0x%0h expected no element (t=%0t)",
                                 bus.out_data, $time);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("elem_data", bus.out_data, e.data);
                        chk("elem_last", bus.out_last, e.last);
                    end
                    hs_cnt++;
                    last_hs_edge = cyc + 1;
                end
                stall = !bus.out_ready;
                stall_data = bus.out_data;
            end else begin
                stall = 1'b0;
                chk("last_without_valid", bus.out_last, 1'b0);
            end
        end
    end

    task automatic push_matrix(input bit cm, input int r, input int c);
        int k;
        k = 0;
        if (!cm) begin
            for (int a = 0; a < r; a++)
                for (int b = 0; b < c; b++) begin
                    sb.push_back('{data: DATA_W'(16 * a + b), last: (k == r * c - 1)});
                    k++;
                end
        end else begin
            for (int b = 0; b < c; b++)
                for (int a = 0; a < r; a++) begin
                    sb.push_back('{data: DATA_W'(16 * a + b), last: (k == r * c - 1)});
                    k++;
                end
        end
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        busy_cnt = 0;
        valid_cnt = 0;
        hs_cnt = 0;
    endtask

    task automatic start_xfer(input bit cm, input int r, input int c);
        @(posedge clk);
        #1;
        clear_counts();
        bus.col_major = cm;
        bus.rows_cfg = IDX_W'(r);
        bus.cols_cfg = IDX_W'(c);
        bus.start = 1'b1;
        start_edge = cyc + 1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        bit found;
        found = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (bus.done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, bound);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_i"}, bus.i, 0);
        chk({tag, "_j"}, bus.j, 0);
        chk({tag, "_data"}, bus.out_data, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_last"}, bus.out_last, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected end within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bus.start = 1'b0;
        bus.col_major = 1'b0;
        bus.rows_cfg = '0;
        bus.cols_cfg = '0;

        // Reset state.
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Row-major 2x3, ready tied high.
        ready_pct = 100;
        push_matrix(1'b0, 2, 3);
        start_xfer(1'b0, 2, 3);
        wait_done("rm", 50);
        repeat (3) @(negedge clk);
        chk("rm_elems", hs_cnt, 6);
        chk("rm_sb_empty", sb.size(), 0);
        chk("rm_done_pulses", done_cnt, 1);
        chk("rm_done_after_last", done_seen_cyc, last_hs_edge);
        // Cycles strictly between the start edge and the last handshake edge.
        chk("rm_start_to_last", last_hs_edge - start_edge - 1, 11);

        // Column-major 2x3.
        push_matrix(1'b1, 2, 3);
        start_xfer(1'b1, 2, 3);
        wait_done("cm", 50);
        repeat (3) @(negedge clk);
        chk("cm_elems", hs_cnt, 6);
        chk("cm_sb_empty", sb.size(), 0);
        chk("cm_done_pulses", done_cnt, 1);

        // 8x8 row-major with sparse ready.
        ready_pct = 30;
        push_matrix(1'b0, 8, 8);
        start_xfer(1'b0, 8, 8);
        wait_done("big", 3000);
        repeat (3) @(negedge clk);
        chk("big_elems", hs_cnt, 64);
        chk("big_sb_empty", sb.size(), 0);
        chk("big_done_pulses", done_cnt, 1);
        ready_pct = 100;

        // Zero rows: no stream, one busy cycle, one done.
        start_xfer(1'b0, 0, 5);
        wait_done("zero", 10);
        repeat (3) @(negedge clk);
        chk("zero_valid_cycles", valid_cnt, 0);
        chk("zero_busy_cycles", busy_cnt, 1);
        chk("zero_done_pulses", done_cnt, 1);

        // Start held high: 1x1 then 8x1; config change mid-transfer must be ignored.
        push_matrix(1'b0, 1, 1);
        push_matrix(1'b0, 8, 1);
        @(posedge clk);
        #1;
        clear_counts();
        bus.col_major = 1'b0;
        bus.rows_cfg = IDX_W'(1);
        bus.cols_cfg = IDX_W'(1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.rows_cfg = IDX_W'(8);
        bus.cols_cfg = IDX_W'(1);
        wait_done("held1", 20);
        @(negedge clk);
        chk("held_idle_gap", bus.busy, 1'b0);
        @(negedge clk);
        chk("held_restart", bus.busy, 1'b1);
        bus.start = 1'b0;
        wait_done("held2", 50);
        repeat (3) @(negedge clk);
        chk("held_elems", hs_cnt, 9);
        chk("held_sb_empty", sb.size(), 0);
        chk("held_done_pulses", done_cnt, 2);

        // Reset during element 5 of 4x4.
        for (int a = 0; a < 4; a++) sb.push_back('{data: DATA_W'(a), last: 1'b0});
        start_xfer(1'b0, 4, 4);
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (hs_cnt >= 4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        ready_hold = 1'b1;
        chk("rst4_four_sent", found, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst4_elem5_valid", found, 1'b1);
        chk("rst4_elem5_data", bus.out_data, 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_sb_empty", sb.size(), 0);
        sb.delete();

        // Start already high when reset releases: must be accepted on the first edge.
        clear_counts();
        ready_hold = 1'b0;
        push_matrix(1'b0, 4, 4);
        bus.col_major = 1'b0;
        bus.rows_cfg = IDX_W'(4);
        bus.cols_cfg = IDX_W'(4);
        bus.start = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("post_rst_first_edge", bus.busy, 1'b1);
        wait_done("post_rst", 100);
        repeat (3) @(negedge clk);
        chk("post_rst_elems", hs_cnt, 16);
        chk("post_rst_sb_empty", sb.size(), 0);
        chk("post_rst_done_pulses", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
